// File: rtl/pn_pkg.sv
// Shared constants for the PN code generator: maximal-length Fibonacci tap masks
// and seeds for register lengths 3..10, plus sequence-period helpers.
package pn_pkg;

  localparam int unsigned PN_MIN_LEN = 3;
  localparam int unsigned PN_MAX_LEN = 10;

  // Bit i set means state[i] joins the feedback parity (x^LEN + sum x^i, primitive).
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_3  = 10'h003;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_4  = 10'h003;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_5  = 10'h005;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_6  = 10'h003;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_7  = 10'h003;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_8  = 10'h01D;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_9  = 10'h011;
  localparam logic [PN_MAX_LEN-1:0] PN_TAPS_10 = 10'h009;

  localparam logic [PN_MAX_LEN-1:0] PN_SEED_DEFAULT = 10'h001;

  function automatic bit pn_len_ok(input int unsigned len);
    return (len >= PN_MIN_LEN) && (len <= PN_MAX_LEN);
  endfunction

  function automatic logic [PN_MAX_LEN-1:0] pn_default_taps(input int unsigned len);
    case (len)
      3:       return PN_TAPS_3;
      4:       return PN_TAPS_4;
      5:       return PN_TAPS_5;
      6:       return PN_TAPS_6;
      7:       return PN_TAPS_7;
      8:       return PN_TAPS_8;
      9:       return PN_TAPS_9;
      10:      return PN_TAPS_10;
      default: return '0;
    endcase
  endfunction

  function automatic logic [PN_MAX_LEN-1:0] pn_default_seed(input int unsigned len);
    return pn_len_ok(len) ? PN_SEED_DEFAULT : '0;
  endfunction

  // Sequence period in chips for a maximal-length register of the given length.
  function automatic int unsigned pn_period(input int unsigned len);
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Registered Fibonacci LFSR: shifts right with the tap parity entering the MSB.
// load_i reloads SEED and wins over step_i; hold_i suppresses a requested step.
module lfsr_step
  import pn_pkg::*;
#(
  parameter int unsigned    LEN  = 7,
  parameter logic [LEN-1:0] TAPS = LEN'(3),
  parameter logic [LEN-1:0] SEED = LEN'(1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step_i,
  input  logic           hold_i,
  input  logic           load_i,
  output logic [LEN-1:0] nxt_o
);

  logic [LEN-1:0] state_q;
  logic [LEN-1:0] state_d;
  logic           feedback;

  always_comb begin
    feedback = ^(state_q & TAPS);
    state_d  = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (step_i && !hold_i) begin
      state_d = {feedback, state_q[LEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state is exported so the owner can register derived outputs in step.
  assign nxt_o = state_d;

endmodule

// File: rtl/pn_code_gen.sv
// Local PN spreading code with chip/epoch/dump strobes and a one-chip slip handshake.
// Define PN_CODE_GEN_GOLD_EN to XOR a second lockstep LFSR into code (Gold code).
module pn_code_gen
  import pn_pkg::*;
#(
  parameter int unsigned         LFSR_LEN        = 7,
  parameter logic [LFSR_LEN-1:0] TAPS            = 7'b0000011,
  parameter logic [LFSR_LEN-1:0] SEED            = 7'b0000001,
`ifdef PN_CODE_GEN_GOLD_EN
  parameter logic [LFSR_LEN-1:0] TAPS2           = 7'b0001001,
  parameter logic [LFSR_LEN-1:0] SEED2           = 7'b0000001,
`endif
  parameter int unsigned         CHIP_DIV        = 4,
  parameter int unsigned         EPOCHS_PER_DUMP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                slip_req,
  output logic                slip_ack,
  output logic                code,
  output logic                chip_stb,
  output logic                epoch,
  output logic                dump,
  output logic [LFSR_LEN-1:0] chip_idx
);

  localparam int unsigned         PERIOD   = pn_period(LFSR_LEN);
  localparam logic [LFSR_LEN-1:0] LAST_IDX = LFSR_LEN'(PERIOD - 1);
  localparam logic [LFSR_LEN-1:0] SEED_EFF = (SEED == '0) ? LFSR_LEN'(1) : SEED;
`ifdef PN_CODE_GEN_GOLD_EN
  localparam logic [LFSR_LEN-1:0] SEED2_EFF = (SEED2 == '0) ? LFSR_LEN'(1) : SEED2;
  localparam logic                CODE_RST  = SEED_EFF[0] ^ SEED2_EFF[0];
`else
  localparam logic                CODE_RST  = SEED_EFF[0];
`endif

  localparam int unsigned      DIV_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHIP_DIV - 1);
  localparam int unsigned      EP_W     = (EPOCHS_PER_DUMP > 1) ? $clog2(EPOCHS_PER_DUMP) : 1;
  localparam logic [EP_W-1:0]  EP_LAST  = EP_W'(EPOCHS_PER_DUMP - 1);

  logic [DIV_W-1:0]    div_cnt_q,      div_cnt_d;
  logic [LFSR_LEN-1:0] chip_idx_q,     chip_idx_d;
  logic [EP_W-1:0]     epoch_cnt_q,    epoch_cnt_d;
  logic                slip_pending_q, slip_pending_d;
  logic                slip_armed_q,   slip_armed_d;
  logic                code_q,         code_d;
  logic                chip_stb_q,     chip_stb_d;
  logic                epoch_q,        epoch_d;
  logic                dump_q,         dump_d;
  logic                slip_ack_q,     slip_ack_d;

  logic                last_div;
  logic                boundary;
  logic                slip_now;
  logic                advance;
  logic                wrap;
  logic                last_epoch;
  logic [LFSR_LEN-1:0] lfsr_nxt;

  // A request arriving in the chip_stb cycle itself is honoured at that same boundary.
  always_comb begin
    last_div   = (div_cnt_q == DIV_LAST);
    boundary   = en && last_div;
    slip_now   = boundary && (slip_pending_q || (slip_req && slip_armed_q));
    advance    = boundary && !slip_now;
    wrap       = advance && (chip_idx_q == LAST_IDX);
    last_epoch = (epoch_cnt_q == EP_LAST);
  end

  always_comb begin
    div_cnt_d   = div_cnt_q;
    chip_idx_d  = chip_idx_q;
    epoch_cnt_d = epoch_cnt_q;
    if (en) begin
      div_cnt_d = last_div ? '0 : div_cnt_q + DIV_W'(1);
    end
    if (advance) begin
      chip_idx_d = wrap ? '0 : chip_idx_q + LFSR_LEN'(1);
    end
    if (wrap) begin
      epoch_cnt_d = last_epoch ? '0 : epoch_cnt_q + EP_W'(1);
    end
  end

  // Re-arming needs slip_req seen low, so a held request yields a single slip.
  always_comb begin
    slip_pending_d = slip_pending_q;
    slip_armed_d   = slip_armed_q;
    if (en) begin
      slip_armed_d = !slip_req;
      if (slip_now) begin
        slip_pending_d = 1'b0;
      end else if (slip_req && slip_armed_q) begin
        slip_pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    chip_stb_d = en && (div_cnt_d == DIV_LAST);
    epoch_d    = wrap;
    dump_d     = wrap && last_epoch;
    slip_ack_d = slip_now;
  end

  lfsr_step #(
    .LEN  (LFSR_LEN),
    .TAPS (TAPS),
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (boundary),
    .hold_i (slip_now),
    .load_i (wrap),
    .nxt_o  (lfsr_nxt)
  );

`ifdef PN_CODE_GEN_GOLD_EN
  logic [LFSR_LEN-1:0] lfsr2_nxt;

  lfsr_step #(
    .LEN  (LFSR_LEN),
    .TAPS (TAPS2),
    .SEED (SEED2_EFF)
  ) u_lfsr2 (
    .clk    (clk),
    .rst    (rst),
    .step_i (boundary),
    .hold_i (slip_now),
    .load_i (wrap),
    .nxt_o  (lfsr2_nxt)
  );

  always_comb begin
    code_d = lfsr_nxt[0] ^ lfsr2_nxt[0];
  end
`else
  always_comb begin
    code_d = lfsr_nxt[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      chip_idx_q     <= '0;
      epoch_cnt_q    <= '0;
      slip_pending_q <= 1'b0;
      slip_armed_q   <= 1'b1;
      code_q         <= CODE_RST;
      chip_stb_q     <= 1'b0;
      epoch_q        <= 1'b0;
      dump_q         <= 1'b0;
      slip_ack_q     <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      chip_idx_q     <= chip_idx_d;
      epoch_cnt_q    <= epoch_cnt_d;
      slip_pending_q <= slip_pending_d;
      slip_armed_q   <= slip_armed_d;
      code_q         <= code_d;
      chip_stb_q     <= chip_stb_d;
      epoch_q        <= epoch_d;
      dump_q         <= dump_d;
      slip_ack_q     <= slip_ack_d;
    end
  end

  assign slip_ack = slip_ack_q;
  assign code     = code_q;
  assign chip_stb = chip_stb_q;
  assign epoch    = epoch_q;
  assign dump     = dump_q;
  assign chip_idx = chip_idx_q;

endmodule

// File: tb/tb_pn_code_gen.sv
// Bench for pn_code_gen (LFSR_LEN=3, CHIP_DIV=2, EPOCHS_PER_DUMP=3): expected strobes are
// queued per scenario and a negedge monitor pops and compares each DUT pulse.
module tb_pn_code_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       slip_req;
  logic       slip_ack;
  logic       code;
  logic       chip_stb;
  logic       epoch;
  logic       dump;
  logic [2:0] chip_idx;

  pn_code_gen #(
    .LFSR_LEN        (3),
    .TAPS            (3'b011),
    .SEED            (3'b001),
`ifdef PN_CODE_GEN_GOLD_EN
    .TAPS2           (3'b101),
    .SEED2           (3'b001),
`endif
    .CHIP_DIV        (2),
    .EPOCHS_PER_DUMP (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .slip_req (slip_req),
    .slip_ack (slip_ack),
    .code     (code),
    .chip_stb (chip_stb),
    .epoch    (epoch),
    .dump     (dump),
    .chip_idx (chip_idx)
  );

`ifdef PN_CODE_GEN_GOLD_EN
  int code_tbl [7] = '{0, 0, 0, 0, 1, 0, 1};
`else
  int code_tbl [7] = '{1, 0, 0, 1, 0, 1, 1};
`endif

  typedef struct { int cyc; int code; int idx; } stb_exp_t;
  typedef struct { int cyc; int dump; } ep_exp_t;

  stb_exp_t stb_q [$];
  ep_exp_t  ep_q  [$];
  int       ack_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  bit mon_on   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Expected cycles are relative to the first cycle after the latest reset.
  task automatic push_chip(input int start, input int k, input bit slipped);
    stb_exp_t e;
    e.cyc  = start + 1;
    e.code = code_tbl[k % 7];
    e.idx  = k % 7;
    stb_q.push_back(e);
    if (slipped) begin
      e.cyc = start + 3;
      stb_q.push_back(e);
    end
  endtask

  task automatic push_ep(input int c, input int d);
    ep_exp_t e;
    e.cyc  = c;
    e.dump = d;
    ep_q.push_back(e);
  endtask

  task automatic goto(input int r);
    while (cyc - base < r) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    base   = cyc;
    mon_on = 1'b1;
    chk("rst_code",     int'(code),     code_tbl[0]);
    chk("rst_chip_idx", int'(chip_idx), 0);
    chk("rst_chip_stb", int'(chip_stb), 0);
    chk("rst_epoch",    int'(epoch),    0);
    chk("rst_dump",     int'(dump),     0);
    chk("rst_slip_ack", int'(slip_ack), 0);
  endtask

  task automatic end_phase();
    mon_on = 1'b0;
    chk("missing_chip_stb", stb_q.size(), 0);
    chk("missing_epoch",    ep_q.size(),  0);
    chk("missing_slip_ack", ack_q.size(), 0);
    stb_q.delete();
    ep_q.delete();
    ack_q.delete();
  endtask

  always @(negedge clk) begin
    stb_exp_t s;
    ep_exp_t  e;
    int       a;
    if (mon_on) begin
      if (chip_stb) begin
        if (stb_q.size() == 0) begin
          chk("unexpected_chip_stb", int'(chip_stb), 0);
        end else begin
          s = stb_q.pop_front();
          chk("chip_stb_cycle", cyc - base,     s.cyc);
          chk("code",           int'(code),     s.code);
          chk("chip_idx",       int'(chip_idx), s.idx);
        end
      end
      if (epoch) begin
        if (ep_q.size() == 0) begin
          chk("unexpected_epoch", int'(epoch), 0);
        end else begin
          e = ep_q.pop_front();
          chk("epoch_cycle", cyc - base, e.cyc);
          chk("dump",        int'(dump), e.dump);
        end
      end else if (dump) begin
        chk("dump_without_epoch", int'(dump), 0);
      end
      if (slip_ack) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_slip_ack", int'(slip_ack), 0);
        end else begin
          a = ack_q.pop_front();
          chk("slip_ack_cycle", cyc - base, a);
        end
      end
    end
  end

  initial begin
    int t;
    bit sl;
    rst      = 1'b1;
    en       = 1'b1;
    slip_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Free run: chip k spans 2k..2k+1, epoch every 14, dump on every third epoch.
    do_reset();
    for (int k = 0; k < 45; k++) push_chip(2 * k, k, 1'b0);
    push_ep(14, 0); push_ep(28, 0); push_ep(42, 1);
    push_ep(56, 0); push_ep(70, 0); push_ep(84, 1);
    goto(90);
    end_phase();

    // Slips at chips 3 (held request), 9 (re-armed), 20 (idx 6, delays wrap), 22 (on stb).
    do_reset();
    t = 0;
    for (int k = 0; k < 28; k++) begin
      sl = (k == 3) || (k == 9) || (k == 20) || (k == 22);
      push_chip(t, k, sl);
      t += sl ? 4 : 2;
    end
    push_ep(16, 0); push_ep(32, 0); push_ep(48, 1); push_ep(64, 0);
    ack_q.push_back(8); ack_q.push_back(22); ack_q.push_back(46); ack_q.push_back(52);
    goto(6);  slip_req = 1'b1;
    goto(16); slip_req = 1'b0;
    goto(20); slip_req = 1'b1;
    goto(22); slip_req = 1'b0;
    goto(44); slip_req = 1'b1;
    goto(46); slip_req = 1'b0;
    goto(51); slip_req = 1'b1;
    goto(52); slip_req = 1'b0;
    goto(65);
    end_phase();

    // Enable low for rel cycles 4..8 while chip 2 sits in its first clk.
    do_reset();
    push_chip(0, 0, 1'b0);
    push_chip(2, 1, 1'b0);
    stb_q.push_back('{cyc: 10, code: code_tbl[2], idx: 2});
    for (int k = 3; k < 9; k++) push_chip(2 * k + 5, k, 1'b0);
    push_ep(19, 0);
    goto(4); en = 1'b0;
    for (int r = 5; r < 9; r++) begin
      goto(r);
      chk("frozen_chip_idx", int'(chip_idx), 2);
      chk("frozen_code",     int'(code),     code_tbl[2]);
    end
    goto(9); en = 1'b1;
    goto(23);
    end_phase();

    // Slip pending when reset hits; request still high afterwards slips chip 0 once.
    do_reset();
    for (int k = 0; k < 3; k++) push_chip(2 * k, k, 1'b0);
    goto(6); slip_req = 1'b1;
    goto(7);
    end_phase();
    do_reset();
    t = 0;
    for (int k = 0; k < 8; k++) begin
      sl = (k == 0);
      push_chip(t, k, sl);
      t += sl ? 4 : 2;
    end
    push_ep(16, 0);
    ack_q.push_back(2);
    goto(4); slip_req = 1'b0;
    goto(18);
    end_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
